// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] HEX_0 = 7'b1000000;
    localparam logic [6:0] HEX_1 = 7'b1111001;
    localparam logic [6:0] HEX_2 = 7'b0100100;
    localparam logic [6:0] HEX_3 = 7'b0110000;
    localparam logic [6:0] HEX_4 = 7'b0011001;
    localparam logic [6:0] HEX_5 = 7'b0010010;
    localparam logic [6:0] HEX_6 = 7'b0000010;
    localparam logic [6:0] HEX_7 = 7'b1111000;
    localparam logic [6:0] HEX_8 = 7'b0000000;
    localparam logic [6:0] HEX_9 = 7'b0010000;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_B = 7'b0000011;
    localparam logic [6:0] HEX_C = 7'b1000110;
    localparam logic [6:0] HEX_D = 7'b0100001;
    localparam logic [6:0] HEX_E = 7'b0000110;
    localparam logic [6:0] HEX_F = 7'b0001110;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  dp_mask;
    } display_buf;

    // Power-up content: every digit dark, so nothing flashes before the first load.
    localparam display_buf BUF_RESET = '{digits: 16'h0000, blank: 4'hF, dp_mask: 4'h0};

    function automatic logic [3:0] an_select(input logic [1:0] idx);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex7_decode.sv
// Combinational hex-nibble to active-low 7-segment pattern decoder.
module hex7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default first so every path assigns seg and no latch is inferred.
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = HEX_0;
            4'h1: seg = HEX_1;
            4'h2: seg = HEX_2;
            4'h3: seg = HEX_3;
            4'h4: seg = HEX_4;
            4'h5: seg = HEX_5;
            4'h6: seg = HEX_6;
            4'h7: seg = HEX_7;
            4'h8: seg = HEX_8;
            4'h9: seg = HEX_9;
            4'hA: seg = HEX_A;
            4'hB: seg = HEX_B;
            4'hC: seg = HEX_C;
            4'hD: seg = HEX_D;
            4'hE: seg = HEX_E;
            4'hF: seg = HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: shadow-buffered load handshake,
// frame-synchronous commit, and an anode-off blanking gap at each slot start.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp_mask,
    output logic        ready,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int              CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          pending;
    display_buf    active_buf;
    display_buf    shadow_buf;

    logic          slot_end;
    logic          frame_end;
    logic          dark;
    logic [3:0]    nibble;
    logic [6:0]    seg_pat;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    assign ready     = ~pending;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Commit has priority; a load can only be accepted while nothing is pending,
    // so a load on the frame-end cycle lands in shadow and waits a full frame.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: both buffers are reset; they are a few flops, not a memory array.
        if (reset) begin
            active_buf <= BUF_RESET;
            shadow_buf <= BUF_RESET;
            pending    <= 1'b0;
        end else if (frame_end && pending) begin
            active_buf <= shadow_buf;
            pending    <= 1'b0;
        end else if (load && !pending) begin
            shadow_buf <= '{digits: digits, blank: blank, dp_mask: dp_mask};
            pending    <= 1'b1;
        end
    end

    assign nibble = active_buf.digits[{idx, 2'b00} +: 4];
    assign dark   = (cnt < BLANK_LIM) || active_buf.blank[idx];

    hex7_decode u_hex7_decode (
        .nibble (nibble),
        .seg    (seg_pat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (dark) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_select(idx);
            seg <= seg_pat;
            dp  <= ~active_buf.dp_mask[idx];
        end
    end

endmodule
